// File: rtl/key_event.sv
// Key gesture decoder: turns a debounced key level into single-click,
// double-click and long-press event pulses, plus a "held" level while a
// long press continues and a wrapping count of every event emitted.
module key_event #(
    parameter int LONG_TICKS = 50000000,
    parameter int DBL_TICKS  = 30000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    output logic       single_p,
    output logic       double_p,
    output logic       long_p,
    output logic       held,
    output logic [7:0] evt_cnt
);

    // Terminal counts: the decision is taken while the tick counter holds
    // the last value of the window, so the state change lands exactly
    // TICKS clocks after entering the state.
    localparam logic [31:0] LONG_LAST = 32'(LONG_TICKS - 1);
    localparam logic [31:0] DBL_LAST  = 32'(DBL_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        WAIT2  = 3'd2,
        PRESS2 = 3'd3,
        LONG   = 3'd4
    } state_t;

    state_t      state_reg, state_next;
    logic [1:0]  sync_reg;          // [0] = s1, [1] = s2
    logic        s2;
    logic [31:0] cnt_reg, cnt_next;
    logic        single_reg, single_next;
    logic        double_reg, double_next;
    logic        long_reg, long_next;
    logic        held_reg, held_next;
    logic [7:0]  evt_cnt_reg, evt_cnt_next;
    logic        any_evt_next;

    // btn has arbitrary phase, so it goes through a two-stage synchronizer
    // and only the second stage is ever looked at.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], btn};
        end
    end

    assign s2 = sync_reg[1];

    // Gesture state machine: next state and the event pulses it produces.
    // Release beats the long threshold in PRESS1; a new press beats the
    // double-click timeout in WAIT2.
    always_comb begin
        state_next  = state_reg;
        single_next = 1'b0;
        double_next = 1'b0;
        long_next   = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (s2) begin
                    state_next = PRESS1;
                end
            end
            PRESS1: begin
                if (!s2) begin
                    state_next = WAIT2;
                end else if (cnt_reg == LONG_LAST) begin
                    state_next = LONG;
                    long_next  = 1'b1;
                end
            end
            WAIT2: begin
                if (s2) begin
                    state_next = PRESS2;
                end else if (cnt_reg == DBL_LAST) begin
                    state_next  = IDLE;
                    single_next = 1'b1;
                end
            end
            PRESS2: begin
                // The second press never turns into a long press.
                if (!s2) begin
                    state_next  = IDLE;
                    double_next = 1'b1;
                end
            end
            LONG: begin
                if (!s2) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Tick counter restarts on every state change so each state measures
    // its own dwell time.
    always_comb begin
        cnt_next = cnt_reg + 32'd1;
        if (state_next != state_reg) begin
            cnt_next = 32'd0;
        end
    end

    // Derived outputs: held follows the LONG state, and the event counter
    // advances together with whichever pulse is being registered.
    always_comb begin
        held_next    = (state_next == LONG);
        any_evt_next = single_next | double_next | long_next;
        evt_cnt_next = evt_cnt_reg + {7'd0, any_evt_next};
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= 32'd0;
            single_reg  <= 1'b0;
            double_reg  <= 1'b0;
            long_reg    <= 1'b0;
            held_reg    <= 1'b0;
            evt_cnt_reg <= 8'd0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            single_reg  <= single_next;
            double_reg  <= double_next;
            long_reg    <= long_next;
            held_reg    <= held_next;
            evt_cnt_reg <= evt_cnt_next;
        end
    end

    assign single_p = single_reg;
    assign double_p = double_reg;
    assign long_p   = long_reg;
    assign held     = held_reg;
    assign evt_cnt  = evt_cnt_reg;

endmodule

// File: doc/key_event.md
KEY_EVENT -- requirements
Module: key_event

Interface
REQ-001 Parameter LONG_TICKS, default 50000000, clocks btn must stay high to count as a long press; legal minimum 2.
REQ-002 Parameter DBL_TICKS, default 30000000, clocks after the first release in which a second press makes a double click; legal minimum 2.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 btn  input  1  debounced key level from the upstream debouncer; 1 = pressed; arbitrary phase relative to clk.
REQ-006 single_p  output  1  one-clock pulse: single click completed.
REQ-007 double_p  output  1  one-clock pulse: double click completed.
REQ-008 long_p  output  1  one-clock pulse: long-press threshold reached.
REQ-009 held  output  1  level; high while in state LONG.
REQ-010 evt_cnt  output  8  running count of all event pulses.

Function
REQ-011 btn SHALL pass through two flip-flops (s1, s2); all decisions use s2 only.
REQ-012 A 32-bit tick counter SHALL clear on every state change and increment by 1 otherwise.
REQ-013 FSM states: IDLE, PRESS1, WAIT2, PRESS2, LONG.
REQ-014 IDLE: s2=1 -> PRESS1; otherwise stay.
REQ-015 PRESS1: s2=0 -> WAIT2; else if cnt==LONG_TICKS-1 -> LONG and assert long_p; release has priority over the threshold in the same cycle.
REQ-016 WAIT2: s2=1 -> PRESS2; else if cnt==DBL_TICKS-1 -> IDLE and assert single_p; a press has priority over the timeout in the same cycle.
REQ-017 PRESS2: s2=0 -> IDLE and assert double_p; no long detection in PRESS2, whatever the hold time.
REQ-018 LONG: held=1; s2=0 -> IDLE; no further long_p while held.
REQ-019 single_p, double_p, long_p and held SHALL be registered and asserted in the clock after the transition decision; each pulse is exactly one clock wide.
REQ-020 Latency: btn rising edge to the first PRESS1 cycle is 3 clocks.
REQ-021 Latency: long_p high LONG_TICKS+3 clocks after the btn rising edge, ±1 clock for input phase.
REQ-022 At most one of single_p, double_p, long_p SHALL be high in any cycle.
REQ-023 evt_cnt SHALL increment by 1 in the cycle any event pulse is high, wrapping 255 -> 0.
REQ-024 held and long_p are mutually consistent: held rises in the same cycle long_p is high.

Reset
REQ-025 While rst=1 at a clk edge: state=IDLE, counter=0, s1=s2=0, all pulses=0, held=0, evt_cnt=0.
REQ-026 Reset mid-operation (any state) SHALL abandon the gesture; no pulse for it is emitted afterwards.
REQ-027 If btn is still high when rst deasserts, the first detection SHALL be treated as a new press (IDLE -> PRESS1).

Verification (LONG_TICKS=10, DBL_TICKS=6)
REQ-028 btn high 4 clk, low 20 clk -> exactly one single_p, DBL_TICKS clocks after the release reaches s2; evt_cnt=1.
REQ-029 btn high 3, low 2, high 3, low 10 -> exactly one double_p at the second release, no single_p; evt_cnt=1.
REQ-030 btn high 30 clk -> long_p once at ~13 clk after the rise; held high until 3 clk after the fall; no single_p or double_p.
REQ-031 btn high 10 clk and releasing on the threshold cycle -> release wins: state WAIT2, no long_p, later single_p.
REQ-032 rst pulsed while in PRESS2 -> no double_p; all outputs 0; btn held high across reset gives a PRESS1 entry 3 clk after rst falls.
REQ-033 256 single clicks -> evt_cnt wraps to 0.
